// File: rtl/aes128_pkg.sv
// Shared definitions for the AES-128 inverse key expander: Rcon, FSM state, GF(2^8) helpers.
// AES_EQINV_KEY_EN adds the InvMixColumns column function used for equivalent-inverse round keys.
package aes128_pkg;

    localparam int AES_KEY_W   = 128;
    localparam int AES_NROUNDS = 10;

    // Round-counter value parked in IDLE for exactly one cycle to mark the done pulse.
    localparam logic [3:0] ROUND_DONE = 4'hF;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } exp_state_t;

    function automatic logic [7:0] rcon(input logic [3:0] i);
        logic [7:0] r;
        case (i)
            4'd1:    r = 8'h01;
            4'd2:    r = 8'h02;
            4'd3:    r = 8'h04;
            4'd4:    r = 8'h08;
            4'd5:    r = 8'h10;
            4'd6:    r = 8'h20;
            4'd7:    r = 8'h40;
            4'd8:    r = 8'h80;
            4'd9:    r = 8'h1b;
            4'd10:   r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h00;
        t = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ t;
            t = xtime(t);
        end
        return p;
    endfunction

`ifdef AES_EQINV_KEY_EN
    // Column is {s0,s1,s2,s3} with s0 in the top byte.
    function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
        logic [7:0] s0, s1, s2, s3;
        logic [7:0] r0, r1, r2, r3;
        {s0, s1, s2, s3} = c;
        r0 = gf_mul(s0, 8'h0e) ^ gf_mul(s1, 8'h0b) ^ gf_mul(s2, 8'h0d) ^ gf_mul(s3, 8'h09);
        r1 = gf_mul(s0, 8'h09) ^ gf_mul(s1, 8'h0e) ^ gf_mul(s2, 8'h0b) ^ gf_mul(s3, 8'h0d);
        r2 = gf_mul(s0, 8'h0d) ^ gf_mul(s1, 8'h09) ^ gf_mul(s2, 8'h0e) ^ gf_mul(s3, 8'h0b);
        r3 = gf_mul(s0, 8'h0b) ^ gf_mul(s1, 8'h0d) ^ gf_mul(s2, 8'h09) ^ gf_mul(s3, 8'h0e);
        return {r0, r1, r2, r3};
    endfunction
`endif

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box: multiplicative inverse in GF(2^8) followed by the affine map.
module aes_sbox
    import aes128_pkg::*;
(
    input  logic [7:0] x,
    output logic [7:0] y
);

    logic [7:0] sq;
    logic [7:0] inv;

    // x^254 = x^(2+4+...+128); zero maps to zero as the S-box requires.
    always_comb begin
        sq  = x;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        y = inv
          ^ {inv[6:0], inv[7]}
          ^ {inv[5:0], inv[7:6]}
          ^ {inv[4:0], inv[7:5]}
          ^ {inv[3:0], inv[7:4]}
          ^ 8'h63;
    end

endmodule

// File: rtl/aes128_inv_key_expander.sv
// AES-128 round-key generator in decryption order (round 10 down to 0), one key per accepted beat.
// AES_EQINV_KEY_EN: rounds 1..9 are emitted through InvMixColumns for the equivalent inverse cipher.
module aes128_inv_key_expander
    import aes128_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] last_key,
    output logic [127:0] rk_data,
    output logic [3:0]   rk_round,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic         busy,
    output logic         done
);

    exp_state_t           state, state_next;
    logic [AES_KEY_W-1:0] key, key_next;
    logic [3:0]           round, round_next;

    logic [31:0] wa, wb, wc, wd;
    logic [31:0] pa, pb, pc, pd;
    logic [31:0] rot, sub;
    logic [AES_KEY_W-1:0] key_prev;
    logic [AES_KEY_W-1:0] key_out;

    assign {wa, wb, wc, wd} = key;
    assign pd  = wd ^ wc;
    assign pc  = wc ^ wb;
    assign pb  = wb ^ wa;
    assign rot = {pd[23:0], pd[31:24]};

    for (genvar g = 0; g < 4; g++) begin : g_subword
        aes_sbox u_sbox (
            .x (rot[8*g +: 8]),
            .y (sub[8*g +: 8])
        );
    end

    assign pa       = wa ^ sub ^ {rcon(round), 24'h000000};
    assign key_prev = {pa, pb, pc, pd};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            key   <= '0;
            round <= 4'd0;
        end else begin
            state <= state_next;
            key   <= key_next;
            round <= round_next;
        end
    end

    // Handshake: a beat transfers on rk_valid && rk_ready; while stalled, key and round hold.
    always_comb begin
        state_next = state;
        key_next   = key;
        round_next = round;
        case (state)
            IDLE: begin
                if (round == ROUND_DONE) round_next = 4'd0;
                if (start) begin
                    state_next = RUN;
                    key_next   = last_key;
                    round_next = 4'(AES_NROUNDS);
                end
            end
            RUN: begin
                if (rk_ready) begin
                    if (round == 4'd0) begin
                        state_next = IDLE;
                        round_next = ROUND_DONE;
                    end else begin
                        key_next   = key_prev;
                        round_next = round - 4'd1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

`ifdef AES_EQINV_KEY_EN
    always_comb begin
        key_out = key;
        if (round != 4'd0 && round != 4'(AES_NROUNDS)) begin
            key_out = {inv_mix_col(key[127:96]), inv_mix_col(key[95:64]),
                       inv_mix_col(key[63:32]),  inv_mix_col(key[31:0])};
        end
    end
`else
    assign key_out = key;
`endif

    assign busy     = (state == RUN);
    assign rk_valid = busy;
    assign rk_round = busy ? round : 4'd0;
    assign rk_data  = busy ? key_out : '0;
    assign done     = (state == IDLE) && (round == ROUND_DONE);

endmodule

// File: tb/tb_aes128_inv_key_expander.sv
// Directed bench for aes128_inv_key_expander using the FIPS-197 AES-128 key schedule.
module tb_aes128_inv_key_expander;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [127:0] last_key;
    logic [127:0] rk_data;
    logic [3:0]   rk_round;
    logic         rk_valid;
    logic         rk_ready;
    logic         busy;
    logic         done;

    int checks   = 0;
    int failures = 0;

    logic [127:0] exp_q[$];
    logic [127:0] fips [0:10];

    aes128_inv_key_expander dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .last_key (last_key),
        .rk_data  (rk_data),
        .rk_round (rk_round),
        .rk_valid (rk_valid),
        .rk_ready (rk_ready),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

`ifdef AES_EQINV_KEY_EN
    function automatic logic [7:0] tb_xt(input logic [7:0] v);
        return v[7] ? ({v[6:0], 1'b0} ^ 8'h1b) : {v[6:0], 1'b0};
    endfunction

    function automatic logic [7:0] tb_mul(input logic [7:0] v, input logic [7:0] c);
        logic [7:0] v2, v4, v8;
        logic [7:0] r;
        v2 = tb_xt(v);
        v4 = tb_xt(v2);
        v8 = tb_xt(v4);
        case (c)
            8'h09:   r = v8 ^ v;
            8'h0b:   r = v8 ^ v2 ^ v;
            8'h0d:   r = v8 ^ v4 ^ v;
            default: r = v8 ^ v4 ^ v2;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] tb_imc(input logic [31:0] w);
        logic [7:0] s [0:3];
        logic [7:0] k [0:3];
        logic [31:0] r;
        k[0] = 8'h0e; k[1] = 8'h0b; k[2] = 8'h0d; k[3] = 8'h09;
        {s[0], s[1], s[2], s[3]} = w;
        r = '0;
        for (int row = 0; row < 4; row++) begin
            logic [7:0] acc;
            acc = 8'h00;
            for (int col = 0; col < 4; col++) acc = acc ^ tb_mul(s[col], k[(col - row + 4) % 4]);
            r[31 - 8*row -: 8] = acc;
        end
        return r;
    endfunction
`endif

    function automatic logic [127:0] expected_beat(input int r);
        logic [127:0] v;
        v = fips[r];
`ifdef AES_EQINV_KEY_EN
        if (r >= 1 && r <= 9) v = {tb_imc(v[127:96]), tb_imc(v[95:64]), tb_imc(v[63:32]), tb_imc(v[31:0])};
`endif
        return v;
    endfunction

    task automatic load_exp();
        exp_q.delete();
        for (int r = 10; r >= 0; r--) exp_q.push_back(expected_beat(r));
    endtask

    task automatic start_run(input logic [127:0] k);
        start    = 1'b1;
        last_key = k;
        rk_ready = 1'b1;
    endtask

    // Caller drives start before the call; the run is followed beat by beat on negedges.
    task automatic do_run(input int stall_round, input int stall_cycles, input int start_round,
                          input int abort_round, input bit b2b, input int exp_done_cyc);
        int cyc       = 0;
        int exp_round = 10;
        int stalls    = stall_cycles;
        bit finished  = 1'b0;
        load_exp();
        while (!finished && cyc < 100) begin
            @(negedge clk);
            start = 1'b0;
            cyc++;
            if (rk_valid) begin
                check_eq($sformatf("rk_round_c%0d", cyc), 128'(rk_round), 128'(exp_round));
                check_eq($sformatf("rk_data_r%0d_c%0d", exp_round, cyc), rk_data,
                         (exp_q.size() > 0) ? exp_q[0] : 128'hx);
                check_eq("busy_in_run", 128'(busy), 128'(1));
                if (exp_round == abort_round) begin
                    rst_n = 1'b0;
                    #1;
                    check_eq("abort_valid", 128'(rk_valid), 128'(0));
                    check_eq("abort_data", rk_data, 128'(0));
                    check_eq("abort_round", 128'(rk_round), 128'(0));
                    check_eq("abort_busy", 128'(busy), 128'(0));
                    repeat (2) begin
                        @(negedge clk);
                        check_eq("abort_no_done", 128'(done), 128'(0));
                    end
                    rst_n    = 1'b1;
                    finished = 1'b1;
                end else if (exp_round == stall_round && stalls > 0) begin
                    rk_ready = 1'b0;
                    stalls--;
                end else begin
                    rk_ready = 1'b1;
                    if (exp_round == start_round) start_run(128'h00112233445566778899aabbccddeeff);
                    void'(exp_q.pop_front());
                    exp_round--;
                end
            end else if (done) begin
                check_eq("done_cycle", 128'(cyc), 128'(exp_done_cyc));
                check_eq("done_busy", 128'(busy), 128'(0));
                check_eq("done_all_beats", 128'(exp_q.size()), 128'(0));
                finished = 1'b1;
                if (b2b) begin
                    start_run(fips[10]);
                end else begin
                    @(negedge clk);
                    check_eq("done_one_cycle", 128'(done), 128'(0));
                    check_eq("idle_after_done", 128'(rk_valid), 128'(0));
                end
            end else begin
                check_eq($sformatf("valid_gap_c%0d", cyc), 128'(rk_valid), 128'(1));
            end
        end
        check_eq("run_timeout", 128'(finished), 128'(1));
    endtask

    initial begin
        fips[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        fips[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        fips[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        fips[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        fips[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        fips[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        fips[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        fips[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        fips[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        fips[9]  = 128'hac7766f319fadc2128d12941575c006e;
        fips[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

        rst_n    = 1'b0;
        start    = 1'b0;
        rk_ready = 1'b0;
        last_key = '0;
        repeat (2) @(negedge clk);
        check_eq("reset_valid", 128'(rk_valid), 128'(0));
        check_eq("reset_data", rk_data, 128'(0));
        check_eq("reset_round", 128'(rk_round), 128'(0));
        check_eq("reset_busy", 128'(busy), 128'(0));
        check_eq("reset_done", 128'(done), 128'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // Plain FIPS-197 run at full throughput.
        start_run(fips[10]);
        do_run(-1, 0, -1, -1, 1'b0, 12);

        // Three-cycle stall on round 5.
        start_run(fips[10]);
        do_run(5, 3, -1, -1, 1'b0, 15);

        // start with a different key mid-run must be ignored.
        start_run(fips[10]);
        do_run(-1, 0, 7, -1, 1'b0, 12);

        // Reset at round 4, then a clean rerun.
        start_run(fips[10]);
        do_run(-1, 0, -1, 4, 1'b0, 0);
        start_run(fips[10]);
        do_run(-1, 0, -1, -1, 1'b0, 12);

        // start coinciding with the round-0 transfer must be ignored.
        start_run(fips[10]);
        do_run(-1, 0, 0, -1, 1'b0, 12);

        // Back-to-back: start in the done cycle.
        start_run(fips[10]);
        do_run(-1, 0, -1, -1, 1'b1, 12);
        do_run(-1, 0, -1, -1, 1'b0, 12);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
